mem_access: RTL and testbench

Memory-stage load/store unit of the naive-mips pipeline. It consumes the EX/MEM pipeline register outputs and drives the data bus with a request/acknowledge handshake. It aligns and extends load data, and presents the write-back triple (`wd`, `wreg`, `wdata`) to MEM/WB. While a bus transaction is outstanding it holds `stallreq` high so that the upstream stages freeze.

---
 rtl/mem_access_pkg.sv | 65 ++++++
 rtl/mem_access_load_align.sv | 26 ++
 rtl/mem_access.sv | 170 +++++++++++++++++
 tb/tb_mem_access.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared aluop encodings and helpers that classify memory ops by access size.
// Bus lane helpers assume little-endian byte order.
package mem_access_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int ALU_OP_BUS   = 8;

  localparam logic [ALU_OP_BUS-1:0] EXE_LB_OP   = 8'b1110_0000;
  localparam logic [ALU_OP_BUS-1:0] EXE_LH_OP   = 8'b1110_0001;
  localparam logic [ALU_OP_BUS-1:0] EXE_LW_OP   = 8'b1110_0011;
  localparam logic [ALU_OP_BUS-1:0] EXE_LBU_OP  = 8'b1110_0100;
  localparam logic [ALU_OP_BUS-1:0] EXE_LHU_OP  = 8'b1110_0101;
  localparam logic [ALU_OP_BUS-1:0] EXE_SB_OP   = 8'b1110_1000;
  localparam logic [ALU_OP_BUS-1:0] EXE_SH_OP   = 8'b1110_1001;
  localparam logic [ALU_OP_BUS-1:0] EXE_SW_OP   = 8'b1110_1011;
  localparam logic [ALU_OP_BUS-1:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [ALU_OP_BUS-1:0] EXE_OR_OP   = 8'b0010_0101;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_t;

  function automatic acc_size_t op_size(input logic [ALU_OP_BUS-1:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: op_size = SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: op_size = SZ_HALF;
      EXE_LW_OP, EXE_SW_OP:             op_size = SZ_WORD;
      default:                          op_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic is_store(input logic [ALU_OP_BUS-1:0] op);
    is_store = (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic misaligned(input acc_size_t sz, input logic [1:0] a);
    case (sz)
      SZ_HALF: misaligned = a[0];
      SZ_WORD: misaligned = |a;
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input acc_size_t sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: byte_en = 4'b0001 << a;
      SZ_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [REG_BUS-1:0] store_data(input acc_size_t sz,
                                                    input logic [REG_BUS-1:0] d);
    case (sz)
      SZ_BYTE: store_data = {4{d[7:0]}};
      SZ_HALF: store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load lane select plus sign/zero extension; purely combinational.
module load_align
  import mem_access_pkg::*;
(
  input  logic [ALU_OP_BUS-1:0] aluop,
  input  logic [1:0]            addr_lo,
  input  logic [REG_BUS-1:0]    rdata,
  output logic [REG_BUS-1:0]    result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[8*addr_lo +: 8];
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (aluop)
      EXE_LB_OP:  result = {{24{lane_b[7]}}, lane_b};
      EXE_LBU_OP: result = {24'h0, lane_b};
      EXE_LH_OP:  result = {{16{lane_h[15]}}, lane_h};
      EXE_LHU_OP: result = {16'h0, lane_h};
      default:    result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: 1-cycle pass-through, memory ops 1+N cycles over a req/ack bus.
// Holds stallreq while a transaction is outstanding; MEM_ACCESS_TIMEOUT_EN adds a watchdog.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  logic [REG_ADDR_BUS-1:0] mem_wd_i,
  input  logic                    mem_wreg_i,
  input  logic [REG_BUS-1:0]      mem_wdata_i,
  input  logic [ALU_OP_BUS-1:0]   mem_aluop_i,
  input  logic [REG_BUS-1:0]      mem_mem_addr_i,
  input  logic [REG_BUS-1:0]      mem_reg2_i,
  input  logic [REG_BUS-1:0]      mem_pc_i,
  output logic                    dbus_req,
  output logic                    dbus_we,
  output logic [REG_BUS-1:0]      dbus_addr,
  output logic [3:0]              dbus_be,
  output logic [REG_BUS-1:0]      dbus_wdata,
  input  logic                    dbus_ack,
  input  logic [REG_BUS-1:0]      dbus_rdata,
  output logic                    wb_valid,
  output logic [REG_ADDR_BUS-1:0] wb_wd,
  output logic                    wb_wreg,
  output logic [REG_BUS-1:0]      wb_wdata,
  output logic                    stallreq,
  output logic                    exc_adel,
  output logic                    exc_ades,
  output logic [REG_BUS-1:0]      exc_badvaddr,
  output logic [REG_BUS-1:0]      exc_epc,
  output logic                    bus_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state;
  logic [ALU_OP_BUS-1:0]   op_q;
  logic [REG_ADDR_BUS-1:0] wd_q;
  logic                    wreg_q;
  logic [1:0]              addr_lo_q;
  logic [REG_BUS-1:0]      load_data;

  acc_size_t sz;
  logic      is_mem;
  logic      mis;
  logic      start;
  logic      pending_load;

  assign sz           = op_size(mem_aluop_i);
  assign is_mem       = (sz != SZ_NONE);
  assign mis          = misaligned(sz, mem_mem_addr_i[1:0]);
  assign start        = valid_i & is_mem & ~mis;
  assign pending_load = (op_size(op_q) != SZ_NONE) & ~is_store(op_q);
  assign stallreq     = ((state == IDLE) & start) | ((state == WAIT) & ~dbus_ack);

  load_align u_load_align (
    .aluop   (op_q),
    .addr_lo (addr_lo_q),
    .rdata   (dbus_rdata),
    .result  (load_data)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0]      wait_cnt;
  logic [REG_BUS-1:0] pc_q;
  logic               bus_err_q;
  assign bus_err = bus_err_q;
`else
  localparam int unused_timeout = TIMEOUT;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= '0;
      wd_q         <= '0;
      wreg_q       <= 1'b0;
      addr_lo_q    <= '0;
      dbus_req     <= 1'b0;
      dbus_we      <= 1'b0;
      dbus_addr    <= '0;
      dbus_be      <= '0;
      dbus_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_wd        <= '0;
      wb_wreg      <= 1'b0;
      wb_wdata     <= '0;
      exc_adel     <= 1'b0;
      exc_ades     <= 1'b0;
      exc_badvaddr <= '0;
      exc_epc      <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      wait_cnt     <= '0;
      pc_q         <= '0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (valid_i && is_mem) begin
            wb_valid <= 1'b0;
            wb_wreg  <= 1'b0;
            wb_wd    <= mem_wd_i;
            if (mis) begin
              exc_adel     <= ~is_store(mem_aluop_i);
              exc_ades     <= is_store(mem_aluop_i);
              exc_badvaddr <= mem_mem_addr_i;
              exc_epc      <= mem_pc_i;
            end else begin
              state      <= WAIT;
              dbus_req   <= 1'b1;
              dbus_we    <= is_store(mem_aluop_i);
              dbus_addr  <= {mem_mem_addr_i[31:2], 2'b00};
              dbus_be    <= byte_en(sz, mem_mem_addr_i[1:0]);
              dbus_wdata <= store_data(sz, mem_reg2_i);
              op_q       <= mem_aluop_i;
              wd_q       <= mem_wd_i;
              wreg_q     <= mem_wreg_i;
              addr_lo_q  <= mem_mem_addr_i[1:0];
`ifdef MEM_ACCESS_TIMEOUT_EN
              wait_cnt   <= '0;
              pc_q       <= mem_pc_i;
`endif
            end
          end else begin
            wb_valid <= valid_i;
            wb_wd    <= mem_wd_i;
            wb_wreg  <= valid_i & mem_wreg_i;
            wb_wdata <= mem_wdata_i;
          end
        end
        WAIT: begin
          // Ack is checked first so it beats a coincident watchdog expiry.
          if (dbus_ack) begin
            state    <= IDLE;
            dbus_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_wd    <= wd_q;
            wb_wreg  <= pending_load & wreg_q;
            wb_wdata <= pending_load ? load_data : '0;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state     <= IDLE;
            dbus_req  <= 1'b0;
            bus_err_q <= 1'b1;
            exc_epc   <= pc_q;
            wb_valid  <= 1'b0;
            wb_wreg   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against a size/lane arithmetic model.
module tb_mem_access;
  import mem_access_pkg::*;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [4:0]  mem_wd_i = '0;
  logic        mem_wreg_i = 1'b0;
  logic [31:0] mem_wdata_i = '0;
  logic [7:0]  mem_aluop_i = '0;
  logic [31:0] mem_mem_addr_i = '0;
  logic [31:0] mem_reg2_i = '0;
  logic [31:0] mem_pc_i = '0;
  logic        dbus_ack = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic        dbus_req, dbus_we, wb_valid, wb_wreg, stallreq;
  logic        exc_adel, exc_ades, bus_err;
  logic [31:0] dbus_addr, dbus_wdata, wb_wdata, exc_badvaddr, exc_epc;
  logic [3:0]  dbus_be;
  logic [4:0]  wb_wd;

  int vec = 0;
  int err = 0;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_wd_i(mem_wd_i),
    .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i), .mem_aluop_i(mem_aluop_i),
    .mem_mem_addr_i(mem_mem_addr_i), .mem_reg2_i(mem_reg2_i), .mem_pc_i(mem_pc_i),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .stallreq(stallreq), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .exc_badvaddr(exc_badvaddr), .exc_epc(exc_epc), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Access size in bytes, 0 for a non-memory op.
  function automatic int ref_bytes(input logic [7:0] op);
    if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
    return 0;
  endfunction

  function automatic bit ref_store(input logic [7:0] op);
    return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> ((a % 4) * 8);
    if (op == EXE_LB_OP || op == EXE_LBU_OP) begin
      v = v & 32'hFF;
      if (op == EXE_LB_OP && v >= 128) v = v - 256;
    end else if (op == EXE_LH_OP || op == EXE_LHU_OP) begin
      v = v & 32'hFFFF;
      if (op == EXE_LH_OP && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  // Drives one instruction and follows it to completion; returns the stalled cycle count.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] alu, input logic [31:0] pc, input int delay,
                        input logic [31:0] rdata, output int stalls);
    int n;
    bit st, mis;
    logic [3:0] exp_be;
    logic [31:0] exp_wdata;
    n = ref_bytes(op);
    st = ref_store(op);
    mis = (n == 2 && addr % 2 != 0) || (n == 4 && addr % 4 != 0);
    exp_be = (n == 1) ? 4'(1 << (addr % 4)) : (n == 2) ? 4'(3 << (addr % 4)) : 4'hF;
    exp_wdata = (n == 1) ? (reg2 & 32'hFF) * 32'h0101_0101 :
                (n == 2) ? (reg2 & 32'hFFFF) * 32'h0001_0001 : reg2;
    stalls = 0;
    valid_i = 1'b1; mem_aluop_i = op; mem_mem_addr_i = addr; mem_reg2_i = reg2;
    mem_wd_i = wd; mem_wreg_i = wreg; mem_wdata_i = alu; mem_pc_i = pc;
    #1;
    vec++;
    if (stallreq !== (n != 0 && !mis))
      begin err++; $display("FAIL %s issue stallreq got %b want %b", tag, stallreq, (n != 0 && !mis)); end
    if (stallreq) stalls++;
    @(negedge clk);
    valid_i = 1'b0; mem_wd_i = 5'($urandom); mem_aluop_i = EXE_ADDU_OP;
    mem_mem_addr_i = $urandom; mem_wreg_i = 1'b1;
    if (n == 0) begin
      vec++;
      if ({wb_valid, wb_wd, wb_wreg, wb_wdata, dbus_req} !== {1'b1, wd, wreg, alu, 1'b0})
        begin err++; $display("FAIL %s passthru wb got %b/%0d/%b/%h req %b want 1/%0d/%b/%h req 0",
                              tag, wb_valid, wb_wd, wb_wreg, wb_wdata, dbus_req, wd, wreg, alu); end
    end else if (mis) begin
      vec++;
      if ({exc_adel, exc_ades, exc_badvaddr, exc_epc, wb_wreg, dbus_req} !==
          {!st, st, addr, pc, 1'b0, 1'b0})
        begin err++; $display("FAIL %s addr_err got adel=%b ades=%b bad=%h epc=%h wreg=%b req=%b want adel=%b ades=%b bad=%h epc=%h",
                              tag, exc_adel, exc_ades, exc_badvaddr, exc_epc, wb_wreg, dbus_req, !st, st, addr, pc); end
      @(negedge clk);
      vec++;
      if ({exc_adel, exc_ades} !== 2'b00)
        begin err++; $display("FAIL %s exc_pulse got %b%b want 00", tag, exc_adel, exc_ades); end
    end else begin
      vec++;
      if ({dbus_req, dbus_we, dbus_addr, dbus_be} !== {1'b1, st, addr & 32'hFFFF_FFFC, exp_be})
        begin err++; $display("FAIL %s bus req=%b we=%b addr=%h be=%b want 1/%b/%h/%b",
                              tag, dbus_req, dbus_we, dbus_addr, dbus_be, st, addr & 32'hFFFF_FFFC, exp_be); end
      if (st) begin
        vec++;
        if (dbus_wdata !== exp_wdata)
          begin err++; $display("FAIL %s store_data got %h want %h", tag, dbus_wdata, exp_wdata); end
      end
      for (int k = 0; k < delay; k++) begin
        #1;
        vec++;
        if ({stallreq, dbus_req, dbus_addr, dbus_be, bus_err} !==
            {1'b1, 1'b1, addr & 32'hFFFF_FFFC, exp_be, 1'b0})
          begin err++; $display("FAIL %s wait%0d stall=%b req=%b addr=%h be=%b err=%b", tag, k,
                                stallreq, dbus_req, dbus_addr, dbus_be, bus_err); end
        if (stallreq) stalls++;
        @(negedge clk);
      end
      dbus_ack = 1'b1; dbus_rdata = rdata;
      #1;
      vec++;
      if (stallreq !== 1'b0)
        begin err++; $display("FAIL %s ack_stall got %b want 0", tag, stallreq); end
      @(negedge clk);
      dbus_ack = 1'b0; dbus_rdata = $urandom;
      vec++;
      if ({wb_valid, wb_wd, wb_wreg, dbus_req} !== {1'b1, wd, st ? 1'b0 : wreg, 1'b0})
        begin err++; $display("FAIL %s done wb got %b/%0d/%b req %b want 1/%0d/%b req 0",
                              tag, wb_valid, wb_wd, wb_wreg, dbus_req, wd, st ? 1'b0 : wreg); end
      if (!st) begin
        vec++;
        if (wb_wdata !== ref_load(op, addr, rdata))
          begin err++; $display("FAIL %s load_data got %h want %h", tag, wb_wdata, ref_load(op, addr, rdata)); end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vec++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, wb_valid, wb_wd, wb_wreg, wb_wdata,
         stallreq, exc_adel, exc_ades, exc_badvaddr, exc_epc, bus_err} !== '0)
      begin err++; $display("FAIL reset outputs not all zero req=%b wb_valid=%b wdata=%h", dbus_req, wb_valid, wb_wdata); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    int s;
    run_op("addu", EXE_ADDU_OP, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234, 32'h400, 0, 32'h0, s);
    vec++;
    if (s !== 0) begin err++; $display("FAIL addu stall_cycles got %0d want 0", s); end
  endtask

  task automatic test_lb();
    int s;
    run_op("lb", EXE_LB_OP, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h0, 32'h404, 2, 32'h80FF_FFFF, s);
    vec++;
    if (s !== 3) begin err++; $display("FAIL lb stall_cycles got %0d want 3", s); end
  endtask

  task automatic test_sh();
    int s;
    run_op("sh", EXE_SH_OP, 32'h2002, 32'hAAAA_5678, 5'd9, 1'b1, 32'h0, 32'h408, 1, 32'h0, s);
  endtask

  task automatic test_misaligned();
    int s;
    run_op("lw_mis", EXE_LW_OP, 32'h3001, 32'h0, 5'd4, 1'b1, 32'h0, 32'h40C, 0, 32'h0, s);
    run_op("sh_mis", EXE_SH_OP, 32'h3003, 32'h55, 5'd4, 1'b1, 32'h0, 32'h410, 0, 32'h0, s);
  endtask

  task automatic test_idle_inputs();
    valid_i = 1'b0; mem_wreg_i = 1'b1; mem_aluop_i = EXE_ADDU_OP; dbus_ack = 1'b1;
    #1;
    vec++;
    if (stallreq !== 1'b0) begin err++; $display("FAIL idle_ack stallreq got %b want 0", stallreq); end
    @(negedge clk);
    dbus_ack = 1'b0;
    vec++;
    if ({wb_valid, wb_wreg, dbus_req} !== 3'b000)
      begin err++; $display("FAIL idle_bubble got valid=%b wreg=%b req=%b want 000", wb_valid, wb_wreg, dbus_req); end
  endtask

  task automatic test_rst_in_wait();
    int s;
    valid_i = 1'b1; mem_aluop_i = EXE_LW_OP; mem_mem_addr_i = 32'h4000; mem_pc_i = 32'h500;
    @(negedge clk);
    valid_i = 1'b0;
    vec++;
    if (dbus_req !== 1'b1) begin err++; $display("FAIL rst_wait pre req got %b want 1", dbus_req); end
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({dbus_req, stallreq} !== 2'b00)
      begin err++; $display("FAIL rst_wait req=%b stall=%b want 00", dbus_req, stallreq); end
    @(negedge clk);
    rst = 1'b0;
    run_op("lw_after_rst", EXE_LW_OP, 32'h4008, 32'h0, 5'd12, 1'b1, 32'h0, 32'h504, 1, 32'hDEAD_BEEF, s);
  endtask

  task automatic test_back_to_back();
    int s;
    run_op("b2b_sw", EXE_SW_OP, 32'h5004, 32'h1357_9BDF, 5'd1, 1'b1, 32'h0, 32'h600, 0, 32'h0, s);
    run_op("b2b_lhu", EXE_LHU_OP, 32'h5006, 32'h0, 5'd2, 1'b1, 32'h0, 32'h604, 0, 32'h8001_7FFF, s);
    run_op("b2b_or", EXE_OR_OP, 32'h0, 32'h0, 5'd5, 1'b1, 32'hCAFE, 32'h608, 0, 32'h0, s);
  endtask

  task automatic test_random();
    logic [7:0] ops [10] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                             EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_ADDU_OP, EXE_OR_OP};
    int s;
    for (int i = 0; i < 60; i++) begin
      run_op("rand", ops[$urandom_range(9)], $urandom, $urandom, 5'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom_range((TO > 4) ? 3 : TO - 1), $urandom, s);
    end
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    valid_i = 1'b1; mem_aluop_i = EXE_LW_OP; mem_mem_addr_i = 32'h7000; mem_pc_i = 32'h700;
    @(negedge clk);
    valid_i = 1'b0;
    for (int k = 0; k < TO; k++) begin
      vec++;
      if ({bus_err, stallreq, dbus_req} !== 3'b011)
        begin err++; $display("FAIL timeout wait%0d err=%b stall=%b req=%b want 011", k, bus_err, stallreq, dbus_req); end
      @(negedge clk);
    end
    vec++;
    if ({bus_err, stallreq, dbus_req, wb_wreg, exc_epc} !== {4'b1000, 32'h700})
      begin err++; $display("FAIL timeout fire err=%b stall=%b req=%b wreg=%b epc=%h want 1/0/0/0/700",
                            bus_err, stallreq, dbus_req, wb_wreg, exc_epc); end
    @(negedge clk);
    vec++;
    if (bus_err !== 1'b0) begin err++; $display("FAIL timeout pulse err=%b want 0", bus_err); end
  endtask
`else
  task automatic test_long_wait();
    int s;
    run_op("lw_long", EXE_LW_OP, 32'h7000, 32'h0, 5'd6, 1'b1, 32'h0, 32'h700, 300, 32'h0BAD_F00D, s);
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_lb();
    test_sh();
    test_misaligned();
    test_idle_inputs();
    test_rst_in_wait();
    test_back_to_back();
    test_random();
`ifdef MEM_ACCESS_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
